ntt_stage_scheduler: RTL and testbench

Sequences a radix-2 NTT pass over an N = 2^LOG_N coefficient memory organised as N/8 rows of 8 lanes, feeding 4 parallel butterfly units.
- Each cycle it issues one row read and the 8 three-bit lane selects for the butterfly output crossbar. The crossbar delays those selects internally by BF_LATENCY cycles.
- It generates the matching write-back strobe BF_LATENCY cycles later.
- It inserts a drain gap between stages so that no row is read before its previous-stage result is written back.

---
 rtl/ntt_stage_scheduler_if.sv | 29 ++
 rtl/ntt_stage_scheduler.sv | 160 ++++++++++++++++
 tb/tb_ntt_stage_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ntt_stage_scheduler_if.sv
// Handshake and row/select bus between the NTT stage scheduler and its host datapath.
// The master drives start; the slave (the scheduler) drives everything else.
interface ntt_stage_scheduler_if #(
  parameter int LOG_N = 10
);
  localparam int ROW_W = LOG_N - 3;
  localparam int STG_W = $clog2(LOG_N);

  logic             start;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [ROW_W-1:0] rd_addr;
  logic [STG_W-1:0] stage;
  logic [23:0]      sel_bus;
  logic             wr_en;
  logic [ROW_W-1:0] wr_addr;
  logic [STG_W-1:0] wr_stage;

  modport master (
    output start,
    input  busy, done, rd_en, rd_addr, stage, sel_bus, wr_en, wr_addr, wr_stage
  );

  modport slave (
    input  start,
    output busy, done, rd_en, rd_addr, stage, sel_bus, wr_en, wr_addr, wr_stage
  );
endinterface

// File: rtl/ntt_stage_scheduler.sv
// Radix-2 NTT pass sequencer: issues row reads with crossbar lane selects, then
// drains the butterfly pipeline before the next stage. Write-back mirrors reads.
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | one row read per cycle, rows 0..R-1 of the current stage
// DRAIN  | BF_LATENCY idle cycles so the stage's last write lands before next reads
// FINISH | single-cycle done pulse, then back to IDLE
module ntt_stage_scheduler #(
  parameter int LOG_N      = 10,
  parameter int BF_LATENCY = 13
) (
  input logic                  clk,
  input logic                  rst,
  ntt_stage_scheduler_if.slave bus
);
  localparam int ROW_W = LOG_N - 3;
  localparam int STG_W = $clog2(LOG_N);
  localparam int DRN_W = $clog2(BF_LATENCY + 1);
  localparam int DLY_W = 1 + ROW_W + STG_W;

  localparam logic [ROW_W-1:0] ROW_LAST = {ROW_W{1'b1}};
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(LOG_N - 1);
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(BF_LATENCY);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [STG_W-1:0] stg_q, stg_d;
  logic [DRN_W-1:0] drn_q, drn_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic [ROW_W-1:0] rd_addr_q, rd_addr_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic [23:0]      sel_q, sel_d;

  logic [BF_LATENCY-1:0][DLY_W-1:0] dly_q, dly_d;

  // Lane j -> {butterfly[1:0], upper half}; from stage 2 on the pattern is fixed.
  function automatic logic [23:0] sel_for(input logic [STG_W-1:0] s);
    logic [23:0] v;
    logic [2:0]  jj;
    v = '0;
    for (int j = 0; j < 8; j++) begin
      jj = 3'(j);
      if (s == STG_W'(0))
        v[3*j +: 3] = jj;
      else if (s == STG_W'(1))
        v[3*j +: 3] = {jj[2], jj[0], jj[1]};
      else
        v[3*j +: 3] = {jj[1:0], jj[2]};
    end
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      stg_q     <= '0;
      drn_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      stage_q   <= '0;
      sel_q     <= '0;
      dly_q     <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      stg_q     <= stg_d;
      drn_q     <= drn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      stage_q   <= stage_d;
      sel_q     <= sel_d;
      dly_q     <= dly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    stg_d   = stg_q;
    drn_d   = drn_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ISSUE;
          row_d   = '0;
          stg_d   = '0;
        end
      end
      ISSUE: begin
        if (row_q == ROW_LAST) begin
          state_d = DRAIN;
          row_d   = '0;
          drn_d   = DRN_LOAD;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      DRAIN: begin
        if (drn_q == DRN_W'(1)) begin
          drn_d = '0;
          if (stg_q == STG_LAST) begin
            state_d = FINISH;
          end else begin
            state_d = ISSUE;
            stg_d   = stg_q + STG_W'(1);
            row_d   = '0;
          end
        end else begin
          drn_d = drn_q - DRN_W'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
        stg_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered with it.
  always_comb begin
    rd_en_d   = (state_d == ISSUE);
    rd_addr_d = rd_en_d ? row_d : '0;
    stage_d   = rd_en_d ? stg_d : '0;
    sel_d     = rd_en_d ? sel_for(stg_d) : '0;
    busy_d    = (state_d == ISSUE) || (state_d == DRAIN);
    done_d    = (state_d == FINISH);
    dly_d     = '0;
    dly_d[0]  = {rd_en_q, rd_addr_q, stage_q};
    for (int i = 1; i < BF_LATENCY; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.stage    = stage_q;
  assign bus.sel_bus  = sel_q;
  assign bus.wr_en    = dly_q[BF_LATENCY-1][DLY_W-1];
  assign bus.wr_addr  = dly_q[BF_LATENCY-1][STG_W +: ROW_W];
  assign bus.wr_stage = dly_q[BF_LATENCY-1][STG_W-1:0];
endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Directed bench for ntt_stage_scheduler with LOG_N=4 (R=2 rows, 4 stages) and BF_LATENCY=13.
module tb_ntt_stage_scheduler;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  ntt_stage_scheduler_if #(.LOG_N(4)) bus ();

  ntt_stage_scheduler #(.LOG_N(4), .BF_LATENCY(13)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed from the lane vectors 0..7 / 0,2,1,3,4,6,5,7 / 0,2,4,6,1,3,5,7.
  logic [23:0] sel_tab [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_rd(input int c);
    return (c >= 1) && (c <= 60) && (((c - 1) % 15) < 2);
  endfunction

  // Cycle c is sampled at the falling edge after rising edge k+c-1; start accepted at edge k.
  task automatic run(input bit poke);
    int  nwr;
    int  last_wr;
    int  s;
    int  p;
    bit  er;
    bit  ew;
    nwr     = 0;
    last_wr = -1;
    bus.start = 1'b1;
    for (int c = 1; c <= 62; c++) begin
      @(negedge clk);
      bus.start = poke && (c == 5 || c == 30 || c == 61);
      s  = (c - 1) / 15;
      p  = (c - 1) % 15;
      er = exp_rd(c);
      ew = exp_rd(c - 13);
      chk($sformatf("rd_en c%0d", c), 32'(bus.rd_en), 32'(er));
      chk($sformatf("rd_addr c%0d", c), 32'(bus.rd_addr), er ? 32'(p) : 32'd0);
      chk($sformatf("stage c%0d", c), 32'(bus.stage), er ? 32'(s) : 32'd0);
      chk($sformatf("sel_bus c%0d", c), 32'(bus.sel_bus), er ? 32'(sel_tab[s]) : 32'd0);
      chk($sformatf("wr_en c%0d", c), 32'(bus.wr_en), 32'(ew));
      chk($sformatf("wr_addr c%0d", c), 32'(bus.wr_addr), ew ? 32'((c - 14) % 15) : 32'd0);
      chk($sformatf("wr_stage c%0d", c), 32'(bus.wr_stage), ew ? 32'((c - 14) / 15) : 32'd0);
      chk($sformatf("busy c%0d", c), 32'(bus.busy), 32'(c <= 60));
      chk($sformatf("done c%0d", c), 32'(bus.done), 32'(c == 61));
      if (bus.wr_en) begin
        nwr++;
        last_wr = c;
      end
    end
    bus.start = 1'b0;
    chk("wr_pulse_count", 32'(nwr), 32'd8);
    chk("last_wr_cycle", 32'(last_wr), 32'd60);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    sel_tab[0] = 24'hFAC688;
    sel_tab[1] = 24'hF74650;
    sel_tab[2] = 24'hF59D10;
    sel_tab[3] = 24'hF59D10;
    rst        = 1'b0;
    bus.start  = 1'b0;

    // Reset held while start toggles.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = ~bus.start;
      chk($sformatf("rst_ctl %0d", i),
          32'({bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.stage,
               bus.wr_en, bus.wr_addr, bus.wr_stage}), 32'd0);
      chk($sformatf("rst_sel %0d", i), 32'(bus.sel_bus), 32'd0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("idle_busy %0d", i), 32'(bus.busy), 32'd0);
      chk($sformatf("idle_rd %0d", i), 32'(bus.rd_en), 32'd0);
    end

    // Plain run, then a run with start poked mid-run and during FINISH.
    run(1'b0);
    @(negedge clk);
    run(1'b1);
    @(negedge clk);
    chk("after_poke_busy", 32'(bus.busy), 32'd0);
    chk("after_poke_rd", 32'(bus.rd_en), 32'd0);

    // Reset during stage 1 drain discards pending writes.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i < 20; i++) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ctl",
        32'({bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.stage,
             bus.wr_en, bus.wr_addr, bus.wr_stage}), 32'd0);
    chk("midrst_sel", 32'(bus.sel_bus), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_wr %0d", i), 32'(bus.wr_en), 32'd0);
      chk($sformatf("post_rst_rd %0d", i), 32'(bus.rd_en), 32'd0);
    end
    run(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
